// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: load funct3 codes, access sizes and FSM states.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FIN  = 2'd2
   } lsu_state_e;

   function automatic logic load_f3_legal(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and replication, load extraction
// and extension, and the alignment/encoding fault check.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        is_store_i,
   input  logic [1:0]  size_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] bus_rdata_i,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   output logic [31:0] ldata_o,
   output logic        fault_o
);

   function automatic logic [31:0] sext8(input logic signed [7:0] v);
      logic signed [31:0] r;
      r = v;
      return r;
   endfunction

   function automatic logic [31:0] sext16(input logic signed [15:0] v);
      logic signed [31:0] r;
      r = v;
      return r;
   endfunction

   logic [31:0] sel;
   assign sel = bus_rdata_i >> {offset_i, 3'b000};

   always_comb begin
      case (size_i)
         SZ_BYTE: fault_o = 1'b0;
         SZ_HALF: fault_o = offset_i[0];
         SZ_WORD: fault_o = |offset_i;
         default: fault_o = 1'b1;
      endcase
      if (!is_store_i && !load_f3_legal(funct3_i)) begin
         fault_o = 1'b1;
      end
   end

   // Loads always fetch the full word; lane selection happens on the return path.
   always_comb begin
      bus_be_o    = 4'b1111;
      bus_wdata_o = wdata_i;
      if (is_store_i) begin
         case (size_i)
            SZ_BYTE: begin
               bus_be_o    = 4'b0001 << offset_i;
               bus_wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
               bus_be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
               bus_wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
               bus_be_o    = 4'b1111;
               bus_wdata_o = wdata_i;
            end
         endcase
      end
   end

   always_comb begin
      case (funct3_i)
         F3_LB:   ldata_o = sext8(sel[7:0]);
         F3_LH:   ldata_o = sext16(sel[15:0]);
         F3_LW:   ldata_o = bus_rdata_i;
         F3_LBU:  ldata_o = {24'd0, sel[7:0]};
         F3_LHU:  ldata_o = {16'd0, sel[15:0]};
         default: ldata_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage: IDLE/REQ/FIN FSM driving a req/ack word bus,
// with a timeout abort and a registered, extended load result.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned ADDR_WIDTH     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  is_store,
   input  logic [1:0]            mem_size,
   input  logic [2:0]            mem_extend,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  misaligned,
   output logic                  bus_err,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [3:0]            bus_be,
   output logic [31:0]           bus_wdata,
   input  logic                  bus_ack,
   input  logic [31:0]           bus_rdata
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES);

   lsu_state_e            state_q;
   logic                  is_store_q;
   logic [1:0]            size_q;
   logic [2:0]            f3_q;
   logic [1:0]            off_q;
   logic [7:0]            cnt_q;
   logic [7:0]            cnt_d;
   logic [31:0]           rdata_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  mis_q;
   logic                  err_q;
   logic                  bus_req_q;
   logic                  bus_we_q;
   logic [ADDR_WIDTH-1:0] bus_addr_q;
   logic [3:0]            bus_be_q;
   logic [31:0]           bus_wdata_q;

   logic                  idle;
   logic [3:0]            al_be;
   logic [31:0]           al_wdata;
   logic [31:0]           al_ldata;
   logic                  al_fault;

   assign idle  = (state_q == IDLE);
   assign cnt_d = cnt_q + 8'd1;

   // In IDLE the aligner judges the incoming request; afterwards it decodes the captured one.
   lsu_align u_align (
      .is_store_i  (idle ? is_store   : is_store_q),
      .size_i      (idle ? mem_size   : size_q),
      .funct3_i    (idle ? mem_extend : f3_q),
      .offset_i    (idle ? addr[1:0]  : off_q),
      .wdata_i     (wdata),
      .bus_rdata_i (bus_rdata),
      .bus_be_o    (al_be),
      .bus_wdata_o (al_wdata),
      .ldata_o     (al_ldata),
      .fault_o     (al_fault)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         is_store_q  <= 1'b0;
         size_q      <= 2'b00;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
         cnt_q       <= 8'd0;
         rdata_q     <= 32'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mis_q       <= 1'b0;
         err_q       <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= 4'b0000;
         bus_wdata_q <= 32'd0;
      end else begin
         done_q <= 1'b0;
         mis_q  <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  is_store_q <= is_store;
                  size_q     <= mem_size;
                  f3_q       <= mem_extend;
                  off_q      <= addr[1:0];
                  if (al_fault) begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                     mis_q   <= 1'b1;
                  end else begin
                     state_q     <= REQ;
                     busy_q      <= 1'b1;
                     cnt_q       <= 8'd0;
                     bus_req_q   <= 1'b1;
                     bus_we_q    <= is_store;
                     bus_addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                     bus_be_q    <= al_be;
                     bus_wdata_q <= al_wdata;
                  end
               end
            end
            REQ: begin
               // An ack arriving on the terminal-count cycle still completes normally.
               if (bus_ack || (cnt_d == TO_LAST)) begin
                  state_q     <= FIN;
                  done_q      <= 1'b1;
                  err_q       <= !bus_ack;
                  busy_q      <= 1'b0;
                  cnt_q       <= 8'd0;
                  bus_req_q   <= 1'b0;
                  bus_we_q    <= 1'b0;
                  bus_addr_q  <= '0;
                  bus_be_q    <= 4'b0000;
                  bus_wdata_q <= 32'd0;
                  if (bus_ack && !is_store_q) begin
                     rdata_q <= al_ldata;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            FIN: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rdata      = rdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign misaligned = mis_q;
   assign bus_err    = err_q;
   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_be     = bus_be_q;
   assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed scenarios plus randomized accesses
// against an arithmetic reference model, with a bus responder and decoupled monitors.
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_store;
   logic [1:0]  mem_size;
   logic [2:0]  mem_extend;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        misaligned;
   logic        bus_err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .is_store   (is_store),
      .mem_size   (mem_size),
      .mem_extend (mem_extend),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .busy       (busy),
      .done       (done),
      .misaligned (misaligned),
      .bus_err    (bus_err),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_be     (bus_be),
      .bus_wdata  (bus_wdata),
      .bus_ack    (bus_ack),
      .bus_rdata  (bus_rdata)
   );

   typedef struct {
      int          done_cyc;
      logic        mis;
      logic        err;
      logic [31:0] rdata;
   } done_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   done_t       sb_q[$];
   bus_t        bus_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          ack_delay = 1000;
   logic [31:0] ack_rdata = 32'd0;
   int          req_cnt = 0;
   logic [31:0] exp_rdata = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   function automatic bit model_fault(bit st, int sz, int ext, logic [31:0] a);
      if (sz == 3) return 1'b1;
      if ((a % (32'd1 << sz)) != 0) return 1'b1;
      if (!st && (ext == 3 || ext == 6 || ext == 7)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bus_t model_bus(bit st, int sz, logic [31:0] a, logic [31:0] wd);
      bus_t r;
      int   b;
      b       = int'(a % 4);
      r.we    = st;
      r.addr  = a - 32'(b);
      r.be    = 4'd15;
      r.wdata = wd;
      if (st && sz == 0) begin
         r.be    = 4'(1 << b);
         r.wdata = (wd & 32'hFF) * 32'h0101_0101;
      end else if (st && sz == 1) begin
         r.be    = 4'(3 << b);
         r.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      end
      return r;
   endfunction

   function automatic logic [31:0] model_load(int ext, logic [31:0] rd, int b);
      logic [31:0] sel;
      int          v;
      sel = rd >> (8 * b);
      case (ext)
         0: begin v = int'(sel & 32'hFF);   if (v >= 128)   v -= 256;   end
         1: begin v = int'(sel & 32'hFFFF); if (v >= 32768) v -= 65536; end
         2: v = int'(rd);
         4: v = int'(sel & 32'hFF);
         5: v = int'(sel & 32'hFFFF);
         default: v = 0;
      endcase
      return 32'(v);
   endfunction

   // ---------------- bus responder ----------------
   always @(negedge clk) begin
      if (bus_req) begin
         if (req_cnt == ack_delay) begin
            bus_ack   = 1'b1;
            bus_rdata = ack_rdata;
         end else begin
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
         end
         req_cnt++;
      end else begin
         bus_ack   = 1'b0;
         bus_rdata = $urandom;
         req_cnt   = 0;
      end
   end

   // ---------------- bus monitor ----------------
   logic prev_req = 1'b0;
   bus_t cur_bus;
   always @(negedge clk) begin
      if (bus_req) begin
         if (!prev_req) begin
            if (bus_q.size() == 0) check("bus_req_unexpected", bus_req, 32'd0);
            else cur_bus = bus_q.pop_front();
         end
         check("bus_we", bus_we, cur_bus.we);
         check("bus_addr", bus_addr, cur_bus.addr);
         check("bus_be", bus_be, cur_bus.be);
         if (cur_bus.we) check("bus_wdata", bus_wdata, cur_bus.wdata);
      end
      prev_req = bus_req;
   end

   // ---------------- completion monitor ----------------
   always @(negedge clk) begin
      done_t e;
      if (done) begin
         if (sb_q.size() == 0) begin
            check("done_unexpected", done, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("misaligned", misaligned, e.mis);
            check("bus_err", bus_err, e.err);
            check("rdata", rdata, e.rdata);
            check("busy_in_fin", busy, 32'd0);
         end
      end else begin
         check("flags_without_done", {misaligned, bus_err}, 32'd0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input bit st, input int sz, input int ext, input logic [31:0] a,
                        input logic [31:0] wd, input int d, input logic [31:0] rd, input bit spur);
      done_t e;
      int    n;
      is_store   = st;
      mem_size   = 2'(sz);
      mem_extend = 3'(ext);
      addr       = a;
      wdata      = wd;
      ack_delay  = d;
      ack_rdata  = rd;
      start      = 1'b1;
      e.mis = 1'b0;
      e.err = 1'b0;
      if (model_fault(st, sz, ext, a)) begin
         e.done_cyc = cyc + 1;
         e.mis      = 1'b1;
      end else begin
         bus_q.push_back(model_bus(st, sz, a, wd));
         if (d < TO) begin
            e.done_cyc = cyc + 2 + d;
            if (!st) exp_rdata = model_load(ext, rd, int'(a % 4));
         end else begin
            e.done_cyc = cyc + 1 + TO;
            e.err      = 1'b1;
         end
      end
      e.rdata = exp_rdata;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < TO + 8) begin
         if (spur && busy) begin
            start    = 1'b1;
            is_store = 1'($urandom);
            mem_size = 2'($urandom);
            addr     = $urandom;
            wdata    = $urandom;
         end
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      if (!done) begin
         check("done_timeout", done, 32'd1);
      end else if (spur) begin
         start = 1'b1;
         addr  = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int          ext, sz, d;
      bit          st;
      logic [31:0] a;
      int          legal_f3[5] = '{0, 1, 2, 4, 5};
      int          bad_f3[3]   = '{3, 6, 7};

      reset = 1'b1; start = 1'b0; is_store = 1'b0; mem_size = 2'b00;
      mem_extend = 3'b000; addr = 32'd0; wdata = 32'd0;
      bus_ack = 1'b0; bus_rdata = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_rdata", rdata, 32'd0);
      check("rst_busy", busy, 32'd0);
      check("rst_done", done, 32'd0);
      check("rst_bus_req", bus_req, 32'd0);
      check("rst_bus_we", bus_we, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_bus_be", bus_be, 32'd0);
      check("rst_bus_wdata", bus_wdata, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // lb / lbu from the upper half of the word
      issue(0, 0, 0, 32'h0000_0106, 32'd0, 0, 32'h80FF_1234, 0);
      check("lb_rdata", rdata, 32'hFFFF_FFFF);
      issue(0, 0, 4, 32'h0000_0106, 32'd0, 0, 32'h80FF_1234, 0);
      check("lbu_rdata", rdata, 32'h0000_00FF);
      // sh to the upper half, acked on the fourth request cycle
      issue(1, 1, 1, 32'h0000_000E, 32'h0000_ABCD, 3, 32'hDEAD_BEEF, 0);
      check("sh_rdata_kept", rdata, 32'h0000_00FF);
      // faults
      issue(0, 2, 2, 32'h0000_0002, 32'd0, 0, 32'h1111_1111, 0);
      issue(1, 3, 0, 32'h0000_0010, 32'h1234_5678, 0, 32'd0, 0);
      issue(0, 2, 6, 32'h0000_0010, 32'd0, 0, 32'h2222_2222, 0);
      check("fault_rdata_kept", rdata, 32'h0000_00FF);
      // timeout, then ack on the terminal-count cycle
      issue(0, 2, 2, 32'h0000_0020, 32'd0, 1000, 32'h3333_3333, 0);
      check("timeout_rdata_kept", rdata, 32'h0000_00FF);
      issue(0, 2, 2, 32'h0000_0024, 32'd0, TO - 1, 32'h1234_5678, 0);
      check("terminal_ack_rdata", rdata, 32'h1234_5678);
      // restarts during REQ and FIN are ignored
      issue(1, 2, 0, 32'h0000_0040, 32'h1122_3344, 2, 32'd0, 1);
      issue(0, 1, 5, 32'h0000_0042, 32'd0, 1, 32'h8765_4321, 1);

      // reset on the second REQ cycle
      is_store = 1'b0; mem_size = 2'b10; mem_extend = 3'b010; addr = 32'h0000_0080;
      ack_delay = 1000; start = 1'b1;
      bus_q.push_back(model_bus(0, 2, 32'h0000_0080, 32'd0));
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_rdata = 32'd0;
      check("midrst_bus_req", bus_req, 32'd0);
      check("midrst_busy", busy, 32'd0);
      check("midrst_done", done, 32'd0);
      check("midrst_rdata", rdata, 32'd0);
      repeat (2) @(negedge clk);
      issue(1, 0, 0, 32'h0000_0003, 32'h0000_005A, 0, 32'd0, 0);

      // randomized accesses
      repeat (300) begin
         st = 1'($urandom);
         if (st) begin
            sz  = int'($urandom_range(0, 3));
            ext = int'($urandom_range(0, 7));
         end else begin
            if ($urandom_range(0, 9) < 8) ext = legal_f3[$urandom_range(0, 4)];
            else ext = bad_f3[$urandom_range(0, 2)];
            sz = ext % 4;
         end
         a = $urandom;
         if ($urandom_range(0, 3) != 0 && sz < 3) a = a & ~((32'd1 << sz) - 32'd1);
         d = int'($urandom_range(0, 5));
         issue(st, sz, ext, a, $urandom, d, $urandom, ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 32'd0);
      check("bus_queue_drained", bus_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage directly downstream of the control unit.
- Consumes the control unit's mem_clk strobe, mem_size, mem_extend (funct3) and addr_sel-selected address. Drives a word-wide req/ack data bus.
- Produces stores with byte-lane enables, and sign- or zero-extended load data for the rd_sel=00 writeback path.
- Raises busy so the PC/instruction clocks can be held while an access is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in REQ without bus_ack before the access aborts with bus_err; range 1..255.
- ADDR_WIDTH, 32: byte address width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle access strobe (mem_clk for stores, load-enable for loads)
- is_store  in  1  1=store, 0=load; sampled with start
- mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal (insn[13:12])
- mem_extend  in  3  load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (insn[14:12])
- addr  in  ADDR_WIDTH  byte address from ALU
- wdata  in  32  store data (rs2), low bits significant
- rdata  out  32  extended load result
- busy  out  1  access in progress
- done  out  1  one-cycle completion pulse
- misaligned  out  1  valid with done: alignment/encoding fault, no bus access made
- bus_err  out  1  valid with done: timeout abort
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  write enable
- bus_addr  out  ADDR_WIDTH  word address, addr with [1:0]=00
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion, single cycle
- bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset: FSM=IDLE; all outputs 0, including rdata; timeout counter 0. Reset asserted mid-access abandons the access at that edge. bus_req is 0 from the next cycle, and no done pulse is produced.
- States: IDLE, REQ, FIN.
- IDLE + start:
  - Capture is_store, mem_size, mem_extend, addr, wdata.
  - Legal access: go to REQ.
  - Faulted access: go to FIN with misaligned=1.
  - busy=1 from the next cycle.
- Faults (checked in IDLE):
  - half with addr[0]=1
  - word with addr[1:0]!=00
  - mem_size=11
  - load with mem_extend in {011,110,111}
- start while busy is ignored and not queued.
- REQ:
  - bus_req=1; bus_we/bus_addr/bus_be/bus_wdata stable for the whole state.
  - bus_ack=1 moves to FIN. On a load, rdata is updated from bus_rdata that same edge.
  - Counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES, go to FIN with bus_err=1; rdata is unchanged.
  - Ack in the same cycle as the timeout terminal count wins: normal completion.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. A start in FIN is ignored.
- Minimum latency: start at cycle N, bus_req at N+1, ack at N+1, done at N+2. Fault: done at N+1.
- Store lanes, with b = addr[1:0]:
  - byte: be = 1<<b, wdata[7:0] replicated x4
  - half: be = 0011 (b=00) or 1100 (b=10), wdata[15:0] replicated x2
  - word: be = 1111
- Loads: bus_be=1111, bus_we=0. Selected = bus_rdata >> 8*b.
  - lb/lh: sign-extend from bit 7/15.
  - lbu/lhu: zero-extend.
  - lw: pass through.
- rdata holds until the next successful load. Stores and faults never modify it.
- misaligned and bus_err are 0 whenever done=0.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state encoding IDLE/REQ/FIN
- One combinational sub-module, lsu_align:
  - inputs: size, funct3, offset, wdata, bus_rdata
  - outputs: bus_be, bus_wdata, extended load data, fault flag
- The FSM, capture registers and timeout counter stay in load_store_unit.

Test Plan:
- lb x7,4(x4) with addr=0x0000_0106, bus_rdata=0x80FF_1234, ack on first REQ cycle -> bus_addr=0x104, bus_be=1111, done at start+2, rdata=0xFFFF_FFFF; same with lbu -> rdata=0x0000_00FF.
- sh with addr=0x0000_000E, wdata=0x0000_ABCD, ack after 3 cycles -> bus_we=1, bus_be=1100, bus_wdata=0xABCD_ABCD, busy high 4 cycles, single done pulse, rdata unchanged.
- lw with addr=0x0000_0002 -> no bus_req, done+misaligned at start+1; mem_size=11 or mem_extend=110 -> same fault response.
- Load, TIMEOUT_CYCLES=4, bus_ack never -> bus_req high 4 cycles, then done+bus_err=1, rdata keeps its prior value; repeat with ack on the terminal-count cycle -> normal completion, bus_err=0.
- Second start pulsed while in REQ and in FIN -> ignored, exactly one bus transaction and one done.
- reset asserted on 2nd REQ cycle -> bus_req=0, busy=0 from the next cycle, no done; a subsequent sb addr=0x3, wdata=0x5A -> bus_be=1000, bus_wdata=0x5A5A_5A5A.
